uop_encode: RTL and testbench
=============================

// Module: uop_encode
// PURPOSE
//  Decode-stage encoder: converts raw RV32I instruction words into the packed
//  micro-op form (uopc, immt, 20-bit packed immediate, register indices) that
//  execute-stage ALU decode and immediate unpack consume.
//  Inverse of immediate unpack: unpack(packed_imm, imm_type) == architectural imm.
//  Sits between fetch queue and rename/dispatch; registered, valid/ready both sides.
// PARAMETERS
//  none (2-entry output skid buffer is fixed)
// PORTS
//  clk         in   1   clock
//  rst_n       in   1   asynchronous reset, active low
//  flush       in   1   sync kill of all held entries (mispredict/redirect)
//  in_valid    in   1   fetch presents inst
//  in_ready    out  1   encoder can accept this cycle
//  in_inst     in   32  raw instruction word
//  in_pc       in   32  pc of in_inst
//  out_valid   out  1   encoded uop available
//  out_ready   in   1   dispatch accepts
//  out_uopcode out  uopc::uopcode_t
//  out_imm_type out immt::imm_type_t
//  out_packed_imm out 20 packed immediate
//  out_rd/out_rs1/out_rs2 out 5 each  register indices (0 if unused by format)
//  out_pc      out  32  pc passthrough
//  out_illegal out  1   unrecognised opcode/funct combination
// BEHAVIOUR
//  Reset (rst_n=0, async): both entries invalid; out_valid=0, in_ready=1,
//   all out_* data =0, out_uopcode = default member, out_illegal=0.
//  Transfer on valid&&ready each side. Latency 1: inst accepted cycle N
//   appears on out_* cycle N+1 when buffer was empty. Output data register-driven.
//  Skid buffer: main reg + skid reg. in_ready = !skid_valid (registered).
//   Accept while main held and !out_ready -> goes to skid. On out fire, skid
//   moves to main. Simultaneous in fire + out fire with skid empty -> main reloads.
//   Order strictly preserved; no drop, no duplicate. Full = both valid -> in_ready=0.
//  flush: next cycle both entries invalid; an in_valid that cycle is discarded.
//   flush wins over simultaneous in/out fire.
//  Held outputs stable while out_valid && !out_ready.
//  Imm packing (bit 19 = inst[31] always; unused packed bits = 0):
//   I (OP-IMM, JALR, LOAD): [18:13]=i[30:25] [12:9]=i[24:21] [8]=i[20]  -> immt::i
//   S (STORE): [18:13]=i[30:25] [12:9]=i[11:8] [8]=i[7]; tagged immt::i
//   B: [18:13]=i[30:25] [12:9]=i[11:8] [8]=i[7] (imm[11])               -> immt::b
//   U: [18:8]=i[30:20] [7:0]=i[19:12]                                   -> immt::u
//   J: [18:13]=i[30:25] [12:9]=i[24:21] [8]=i[20] [7:0]=i[19:12]       -> immt::j
//  Shift-imm (slli/srli/srai): funct7 must be 0x00/0x00/0x20 else illegal;
//   packed imm carries shamt in [12:8], [19:13]=0.
//  R-type: funct7 0x00 or 0x20 (sub/sra only) else illegal; packed_imm=0.
//  Illegal: out_illegal=1, uopc default member, imm/regs 0; still flows in order.
// STRUCTURE
//  rv32i_types: add uopc members for loads/stores/jal if absent, opcode constants,
//   immt::imm_type_t, uop_t packed struct bundling all out_* fields.
//  Sub-module imm_pack (combinational: inst, format -> packed_imm, imm_type).
//  Top: comb field decode -> uop_t -> 2-entry skid buffer.
// TESTING
//  addi x1,x0,-1 (0xFFF00093) -> uopc::addi, immt::i, packed 0xFFF00, rd=1, rs1=0.
//  lui x5,0x12345 (0x123452B7) -> uopc::lui, immt::u, packed 0x12345, rd=5.
//  jal x0,-4 (0xFFDFF06F) -> immt::j, packed 0xFFDFF; unpack gives 0xFFFFFFFC.
//  beq x0,x0,+8 (0x00000463) -> uopc::beq, immt::b, packed 0x00800.
//  Backpressure: 4 back-to-back insts, out_ready=0 for 3 cycles -> in_ready
//   drops after 2 accepted; release -> all 4 exit in order, none lost.
//  flush with 2 held + in_valid -> out_valid=0 next cycle; rst_n low mid-stream
//   -> out_valid=0 immediately (async); 0x00000000 -> out_illegal=1.

Source files
------------

// File: rtl/uop_encode_pkg.sv
// Shared RV32I decode types: opcode constants, micro-op codes, immediate
// formats and the packed micro-op bundle carried through the skid buffer.
package uop_encode_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    // UOP_NONE is the default member, used for illegal instructions and reset.
    typedef enum logic [5:0] {
        UOP_NONE,
        UOP_LUI, UOP_AUIPC, UOP_JAL, UOP_JALR,
        UOP_BEQ, UOP_BNE, UOP_BLT, UOP_BGE, UOP_BLTU, UOP_BGEU,
        UOP_LB, UOP_LH, UOP_LW, UOP_LBU, UOP_LHU,
        UOP_SB, UOP_SH, UOP_SW,
        UOP_ADDI, UOP_SLTI, UOP_SLTIU, UOP_XORI, UOP_ORI, UOP_ANDI,
        UOP_SLLI, UOP_SRLI, UOP_SRAI,
        UOP_ADD, UOP_SUB, UOP_SLL, UOP_SLT, UOP_SLTU,
        UOP_XOR, UOP_SRL, UOP_SRA, UOP_OR, UOP_AND
    } uopcode_t;

    typedef enum logic [1:0] {
        IMMT_I,
        IMMT_B,
        IMMT_U,
        IMMT_J
    } imm_type_t;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_SH,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } fmt_t;

    typedef struct packed {
        uopcode_t    uopcode;
        imm_type_t   imm_type;
        logic [19:0] packed_imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] pc;
        logic        illegal;
    } uop_t;

    function automatic logic [4:0] reg_if(input logic en, input logic [4:0] idx);
        return en ? idx : 5'd0;
    endfunction

endpackage

// File: rtl/uop_encode_imm_pack.sv
// Combinational immediate packer: folds the format-specific immediate bit
// scatter of an RV32I word into the 20-bit packed form plus its type tag.
module uop_encode_imm_pack
    import uop_encode_pkg::*;
(
    input  logic [31:7] i_bits,
    input  fmt_t        i_fmt,
    output logic [19:0] o_packed_imm,
    output imm_type_t   o_imm_type
);

    always_comb begin
        o_packed_imm = '0;
        o_imm_type   = IMMT_I;
        case (i_fmt)
            FMT_I: o_packed_imm = {i_bits[31], i_bits[30:25], i_bits[24:21], i_bits[20], 8'h00};
            // Stores share the I layout so the unpacker treats them as I-type.
            FMT_S: o_packed_imm = {i_bits[31], i_bits[30:25], i_bits[11:8], i_bits[7], 8'h00};
            FMT_B: begin
                o_packed_imm = {i_bits[31], i_bits[30:25], i_bits[11:8], i_bits[7], 8'h00};
                o_imm_type   = IMMT_B;
            end
            FMT_U: begin
                o_packed_imm = {i_bits[31], i_bits[30:20], i_bits[19:12]};
                o_imm_type   = IMMT_U;
            end
            FMT_J: begin
                o_packed_imm = {i_bits[31], i_bits[30:25], i_bits[24:21], i_bits[20], i_bits[19:12]};
                o_imm_type   = IMMT_J;
            end
            FMT_SH: o_packed_imm = {7'd0, i_bits[24:20], 8'h00};
            default: o_packed_imm = '0;
        endcase
    end

endmodule

// File: rtl/uop_encode.sv
// RV32I decode-stage encoder: field decode into a uop_t, then a 2-entry
// skid buffer (main + skid) with valid/ready on both sides.
module uop_encode
    import uop_encode_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output uopcode_t    out_uopcode,
    output imm_type_t   out_imm_type,
    output logic [19:0] out_packed_imm,
    output logic [4:0]  out_rd,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [31:0] out_pc,
    output logic        out_illegal
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    uopcode_t    w_op;
    fmt_t        w_fmt;
    logic        w_use_rd;
    logic        w_use_rs1;
    logic        w_use_rs2;
    logic        w_legal;
    logic [19:0] w_imm;
    imm_type_t   w_immt;
    uop_t        w_uop;

    uop_t        r_main;
    uop_t        r_skid;
    logic        r_main_valid;
    logic        r_skid_valid;
    logic        w_in_fire;
    logic        w_out_fire;

    assign w_opcode = in_inst[6:0];
    assign w_funct3 = in_inst[14:12];
    assign w_funct7 = in_inst[31:25];

    always_comb begin
        w_op      = UOP_NONE;
        w_fmt     = FMT_R;
        w_use_rd  = 1'b0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        case (w_opcode)
            OPC_LUI:   begin w_op = UOP_LUI;   w_fmt = FMT_U; w_use_rd = 1'b1; end
            OPC_AUIPC: begin w_op = UOP_AUIPC; w_fmt = FMT_U; w_use_rd = 1'b1; end
            OPC_JAL:   begin w_op = UOP_JAL;   w_fmt = FMT_J; w_use_rd = 1'b1; end
            OPC_JALR: begin
                w_fmt = FMT_I; w_use_rd = 1'b1; w_use_rs1 = 1'b1;
                if (w_funct3 == 3'd0) w_op = UOP_JALR;
            end
            OPC_BRANCH: begin
                w_fmt = FMT_B; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
                case (w_funct3)
                    3'd0: w_op = UOP_BEQ;
                    3'd1: w_op = UOP_BNE;
                    3'd4: w_op = UOP_BLT;
                    3'd5: w_op = UOP_BGE;
                    3'd6: w_op = UOP_BLTU;
                    3'd7: w_op = UOP_BGEU;
                    default: w_op = UOP_NONE;
                endcase
            end
            OPC_LOAD: begin
                w_fmt = FMT_I; w_use_rd = 1'b1; w_use_rs1 = 1'b1;
                case (w_funct3)
                    3'd0: w_op = UOP_LB;
                    3'd1: w_op = UOP_LH;
                    3'd2: w_op = UOP_LW;
                    3'd4: w_op = UOP_LBU;
                    3'd5: w_op = UOP_LHU;
                    default: w_op = UOP_NONE;
                endcase
            end
            OPC_STORE: begin
                w_fmt = FMT_S; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
                case (w_funct3)
                    3'd0: w_op = UOP_SB;
                    3'd1: w_op = UOP_SH;
                    3'd2: w_op = UOP_SW;
                    default: w_op = UOP_NONE;
                endcase
            end
            OPC_OPIMM: begin
                w_fmt = FMT_I; w_use_rd = 1'b1; w_use_rs1 = 1'b1;
                case (w_funct3)
                    3'd0: w_op = UOP_ADDI;
                    3'd2: w_op = UOP_SLTI;
                    3'd3: w_op = UOP_SLTIU;
                    3'd4: w_op = UOP_XORI;
                    3'd6: w_op = UOP_ORI;
                    3'd7: w_op = UOP_ANDI;
                    3'd1: begin
                        w_fmt = FMT_SH;
                        if (w_funct7 == F7_BASE) w_op = UOP_SLLI;
                    end
                    default: begin
                        w_fmt = FMT_SH;
                        if (w_funct7 == F7_BASE)     w_op = UOP_SRLI;
                        else if (w_funct7 == F7_ALT) w_op = UOP_SRAI;
                    end
                endcase
            end
            OPC_OP: begin
                w_fmt = FMT_R; w_use_rd = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
                if (w_funct7 == F7_BASE) begin
                    case (w_funct3)
                        3'd0: w_op = UOP_ADD;
                        3'd1: w_op = UOP_SLL;
                        3'd2: w_op = UOP_SLT;
                        3'd3: w_op = UOP_SLTU;
                        3'd4: w_op = UOP_XOR;
                        3'd5: w_op = UOP_SRL;
                        3'd6: w_op = UOP_OR;
                        default: w_op = UOP_AND;
                    endcase
                end else if (w_funct7 == F7_ALT) begin
                    if (w_funct3 == 3'd0)      w_op = UOP_SUB;
                    else if (w_funct3 == 3'd5) w_op = UOP_SRA;
                end
            end
            default: w_op = UOP_NONE;
        endcase
    end

    assign w_legal = (w_op != UOP_NONE);

    uop_encode_imm_pack u_imm_pack (
        .i_bits       (in_inst[31:7]),
        .i_fmt        (w_fmt),
        .o_packed_imm (w_imm),
        .o_imm_type   (w_immt)
    );

    // Illegal words still flow in order, but carry no operands or immediate.
    always_comb begin
        w_uop.uopcode    = w_op;
        w_uop.imm_type   = w_legal ? w_immt : IMMT_I;
        w_uop.packed_imm = w_legal ? w_imm : 20'd0;
        w_uop.rd         = reg_if(w_legal && w_use_rd,  in_inst[11:7]);
        w_uop.rs1        = reg_if(w_legal && w_use_rs1, in_inst[19:15]);
        w_uop.rs2        = reg_if(w_legal && w_use_rs2, in_inst[24:20]);
        w_uop.pc         = in_pc;
        w_uop.illegal    = !w_legal;
    end

    assign in_ready   = !r_skid_valid;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_main_valid && out_ready;

    // The skid entry only fills while main is held, so in_ready (= !skid)
    // guarantees no input arrives in the cycle skid drains into main.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main       <= '0;
            r_skid       <= '0;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_out_fire) begin
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_skid_valid <= 1'b0;
            end else if (w_in_fire) begin
                r_main <= w_uop;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_in_fire) begin
            if (!r_main_valid) begin
                r_main       <= w_uop;
                r_main_valid <= 1'b1;
            end else begin
                r_skid       <= w_uop;
                r_skid_valid <= 1'b1;
            end
        end
    end

    assign out_valid      = r_main_valid;
    assign out_uopcode    = r_main.uopcode;
    assign out_imm_type   = r_main.imm_type;
    assign out_packed_imm = r_main.packed_imm;
    assign out_rd         = r_main.rd;
    assign out_rs1        = r_main.rs1;
    assign out_rs2        = r_main.rs2;
    assign out_pc         = r_main.pc;
    assign out_illegal    = r_main.illegal;

endmodule

// File: tb/tb_uop_encode.sv
// Scoreboard bench for uop_encode: directed RV32I words, backpressure, flush,
// async reset and randomized traffic against an architectural-immediate model.
module tb_uop_encode;
    import uop_encode_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    uopcode_t    out_uopcode;
    imm_type_t   out_imm_type;
    logic [19:0] out_packed_imm;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [31:0] out_pc;
    logic        out_illegal;

    always #5 clk = ~clk;

    uop_encode dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_inst        (in_inst),
        .in_pc          (in_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_uopcode    (out_uopcode),
        .out_imm_type   (out_imm_type),
        .out_packed_imm (out_packed_imm),
        .out_rd         (out_rd),
        .out_rs1        (out_rs1),
        .out_rs2        (out_rs2),
        .out_pc         (out_pc),
        .out_illegal    (out_illegal)
    );

    typedef struct {
        uop_t        u;
        logic [31:0] arch;
        logic        chk_imm;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] pc_ctr = 32'h0000_1000;
    logic        last_fire;
    logic        prev_hold = 1'b0;
    uop_t        prev_snap;

    task automatic check(input string name, input logic ok, input logic [79:0] got, input logic [79:0] want);
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %h required %h at %0t", name, got, want, $time);
        end
    endtask

    function automatic uop_t cur_out();
        uop_t c;
        c.uopcode = out_uopcode; c.imm_type = out_imm_type; c.packed_imm = out_packed_imm;
        c.rd = out_rd; c.rs1 = out_rs1; c.rs2 = out_rs2; c.pc = out_pc; c.illegal = out_illegal;
        return c;
    endfunction

    // Architectural immediate -> packed form, derived from the immediate bit numbering.
    function automatic logic [19:0] pack_imm(input imm_type_t t, input logic [31:0] imm);
        case (t)
            IMMT_B:  return {imm[12], imm[10:5], imm[4:1], imm[11], 8'h00};
            IMMT_U:  return imm[31:12];
            IMMT_J:  return {imm[20], imm[10:1], imm[11], imm[19:12]};
            default: return {imm[11:0], 8'h00};
        endcase
    endfunction

    function automatic logic [31:0] unpack_imm(input imm_type_t t, input logic [19:0] p);
        case (t)
            IMMT_B:  return {{19{p[19]}}, p[19], p[8], p[18:13], p[12:9], 1'b0};
            IMMT_U:  return {p, 12'h000};
            IMMT_J:  return {{11{p[19]}}, p[19], p[7:0], p[8], p[18:9], 1'b0};
            default: return {{20{p[19]}}, p[19:8]};
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc);
        exp_t      e;
        uopcode_t  op = UOP_NONE;
        imm_type_t t = IMMT_I;
        logic [31:0] imm = '0;
        logic has_imm = 1'b0, shift = 1'b0, ud = 1'b0, u1 = 1'b0, u2 = 1'b0;
        logic [2:0] f3 = w[14:12];
        logic [6:0] f7 = w[31:25];
        uopcode_t br_tab[8], ld_tab[8], st_tab[8], oi_tab[8], op_tab[8];
        logic [31:0] i_imm = {{20{w[31]}}, w[31:20]};
        logic [31:0] s_imm = {{20{w[31]}}, w[31:25], w[11:7]};
        logic [31:0] b_imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        logic [31:0] u_imm = {w[31:12], 12'h000};
        logic [31:0] j_imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        br_tab = '{UOP_BEQ, UOP_BNE, UOP_NONE, UOP_NONE, UOP_BLT, UOP_BGE, UOP_BLTU, UOP_BGEU};
        ld_tab = '{UOP_LB, UOP_LH, UOP_LW, UOP_NONE, UOP_LBU, UOP_LHU, UOP_NONE, UOP_NONE};
        st_tab = '{UOP_SB, UOP_SH, UOP_SW, UOP_NONE, UOP_NONE, UOP_NONE, UOP_NONE, UOP_NONE};
        oi_tab = '{UOP_ADDI, UOP_NONE, UOP_SLTI, UOP_SLTIU, UOP_XORI, UOP_NONE, UOP_ORI, UOP_ANDI};
        op_tab = '{UOP_ADD, UOP_SLL, UOP_SLT, UOP_SLTU, UOP_XOR, UOP_SRL, UOP_OR, UOP_AND};
        case (w[6:0])
            7'h37: begin op = UOP_LUI;   t = IMMT_U; imm = u_imm; has_imm = 1; ud = 1; end
            7'h17: begin op = UOP_AUIPC; t = IMMT_U; imm = u_imm; has_imm = 1; ud = 1; end
            7'h6F: begin op = UOP_JAL;   t = IMMT_J; imm = j_imm; has_imm = 1; ud = 1; end
            7'h67: begin op = (f3 == 0) ? UOP_JALR : UOP_NONE; imm = i_imm; has_imm = 1; ud = 1; u1 = 1; end
            7'h63: begin op = br_tab[f3]; t = IMMT_B; imm = b_imm; has_imm = 1; u1 = 1; u2 = 1; end
            7'h03: begin op = ld_tab[f3]; imm = i_imm; has_imm = 1; ud = 1; u1 = 1; end
            7'h23: begin op = st_tab[f3]; imm = s_imm; has_imm = 1; u1 = 1; u2 = 1; end
            7'h13: begin
                ud = 1; u1 = 1;
                if (f3 == 1) begin shift = 1; op = (f7 == 0) ? UOP_SLLI : UOP_NONE; end
                else if (f3 == 5) begin
                    shift = 1;
                    op = (f7 == 0) ? UOP_SRLI : (f7 == 7'h20) ? UOP_SRAI : UOP_NONE;
                end else begin op = oi_tab[f3]; imm = i_imm; has_imm = 1; end
            end
            7'h33: begin
                ud = 1; u1 = 1; u2 = 1;
                if (f7 == 0) op = op_tab[f3];
                else if (f7 == 7'h20) op = (f3 == 0) ? UOP_SUB : (f3 == 5) ? UOP_SRA : UOP_NONE;
            end
            default: op = UOP_NONE;
        endcase
        e.u = '0;
        e.u.pc = pc;
        e.arch = imm;
        e.chk_imm = 1'b0;
        if (op == UOP_NONE) begin
            e.u.illegal = 1'b1;
        end else begin
            e.u.uopcode  = op;
            e.u.imm_type = t;
            e.u.rd  = ud ? w[11:7]  : 5'd0;
            e.u.rs1 = u1 ? w[19:15] : 5'd0;
            e.u.rs2 = u2 ? w[24:20] : 5'd0;
            if (shift)        e.u.packed_imm = {7'd0, w[24:20], 8'h00};
            else if (has_imm) e.u.packed_imm = pack_imm(t, imm);
            e.chk_imm = has_imm;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0] opcs[9];
        logic [31:0] w = $urandom;
        int unsigned k = $urandom_range(0, 9);
        int unsigned r = $urandom_range(0, 3);
        opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
        if (k < 9) w[6:0] = opcs[k];
        if (r == 0) w[31:25] = 7'h00;
        else if (r == 1) w[31:25] = 7'h20;
        return w;
    endfunction

    // Entered just after a rising edge; returns just after the next one.
    task automatic step(input logic v, input logic [31:0] inst, input logic ordy, input logic fl);
        in_valid = v; in_inst = inst; in_pc = pc_ctr; out_ready = ordy; flush = fl;
        @(negedge clk);
        last_fire = v && in_ready && !fl;
        if (fl) exp_q.delete();
        else if (v && in_ready) exp_q.push_back(model(inst, pc_ctr));
        if (v && in_ready) pc_ctr += 32'd4;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        uop_t c;
        exp_t e;
        c = cur_out();
        if (rst_n) begin
            if (prev_hold) check("hold_stable", c == prev_snap, 80'(c), 80'(prev_snap));
            if (out_valid && out_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 1'b0, 80'(c), 80'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("uop", c == e.u, 80'(c), 80'(e.u));
                    if (e.chk_imm)
                        check("unpack", unpack_imm(out_imm_type, out_packed_imm) == e.arch,
                              80'(unpack_imm(out_imm_type, out_packed_imm)), 80'(e.arch));
                end
            end
            prev_hold = out_valid && !out_ready && !flush;
            prev_snap = c;
        end else begin
            prev_hold = 1'b0;
        end
    end

    logic [31:0] directed[8];
    logic [31:0] bp[4];
    int          sent;
    int          budget;

    initial begin
        directed = '{32'hFFF00093, 32'h123452B7, 32'hFFDFF06F, 32'h00000463,
                     32'h00000000, 32'h40315093, 32'hFE312E23, 32'h40B50533};
        bp = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213};
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;
        #12;
        check("reset_out_valid", out_valid == 1'b0, 80'(out_valid), 80'd0);
        check("reset_in_ready", in_ready == 1'b1, 80'(in_ready), 80'd1);
        check("reset_data", cur_out() == uop_t'('0), 80'(cur_out()), 80'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (directed[i]) step(1'b1, directed[i], 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        sent = 0;
        for (int c = 0; c < 12; c++) begin
            step(sent < 4, bp[sent % 4], c >= 3, 1'b0);
            if (last_fire) sent++;
            if (c == 1) check("bp_in_ready_full", in_ready == 1'b0, 80'(in_ready), 80'd0);
        end
        check("bp_accepted", sent == 4, 80'(sent), 80'd4);

        step(1'b1, bp[0], 1'b0, 1'b0);
        step(1'b1, bp[1], 1'b0, 1'b0);
        step(1'b1, bp[2], 1'b0, 1'b1);
        check("flush_full_valid", out_valid == 1'b0, 80'(out_valid), 80'd0);
        check("flush_full_ready", in_ready == 1'b1, 80'(in_ready), 80'd1);
        step(1'b1, bp[3], 1'b0, 1'b0);
        step(1'b1, 32'h00500293, 1'b1, 1'b1);
        check("flush_one_valid", out_valid == 1'b0, 80'(out_valid), 80'd0);
        step(1'b1, 32'h00600313, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        step(1'b1, bp[0], 1'b0, 1'b0);
        step(1'b1, bp[1], 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid == 1'b0, 80'(out_valid), 80'd0);
        check("async_rst_ready", in_ready == 1'b1, 80'(in_ready), 80'd1);
        exp_q.delete();
        @(negedge clk); @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int n = 0; n < 3000; n++)
            step($urandom_range(0, 99) < 70, rand_inst(), $urandom_range(0, 99) < 65,
                 $urandom_range(0, 99) < 3);

        budget = 0;
        while ((exp_q.size() != 0 || out_valid) && budget < 20) begin
            step(1'b0, '0, 1'b1, 1'b0);
            budget++;
        end
        check("drain", exp_q.size() == 0 && !out_valid, 80'(exp_q.size()), 80'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
